// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder (dmem_responder).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dmem_op_t;

  localparam int WS_W = 4;

endpackage

// File: rtl/dmem_if.sv
// Core data-port bundle between the core (master) and dmem_responder (slave).
// Optional DMEM_BYTE_EN adds the d_be byte-enable lane.
interface dmem_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] daddr;
  logic [DW-1:0] ddata_w;
`ifdef DMEM_BYTE_EN
  logic [DW/8-1:0] d_be;
`endif
  logic          d_ready;
  logic          d_rvalid;
  logic [DW-1:0] ddata_r;

`ifdef DMEM_BYTE_EN
  modport master (output MemRead, MemWrite, daddr, ddata_w, d_be,
                  input  d_ready, d_rvalid, ddata_r);
  modport slave  (input  MemRead, MemWrite, daddr, ddata_w, d_be,
                  output d_ready, d_rvalid, ddata_r);
`else
  modport master (output MemRead, MemWrite, daddr, ddata_w,
                  input  d_ready, d_rvalid, ddata_r);
  modport slave  (input  MemRead, MemWrite, daddr, ddata_w,
                  output d_ready, d_rvalid, ddata_r);
`endif
endinterface

// File: rtl/dmem_array.sv
// Word storage with per-byte synchronous write and a registered, resettable read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic            re,
  input  logic            rzero,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // storage write, byte lanes gated by be (storage itself is never reset)
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // read register; holds its value across writes and idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= rzero ? {DW{1'b0}} : mem_r[addr];
    end
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request at a time, fixed latency, one-cycle d_rvalid.
// Define DMEM_BYTE_EN to enable per-byte write masking through d_be.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int data_size    = 1024,
  parameter int address_size = 32,
  parameter int WAIT_STATES  = 1
) (
  input logic   CLK,
  input logic   RESET_N,
  dmem_if.slave bus
);
  localparam int AW = $clog2(data_size - 1);
  localparam int DW = address_size;
  localparam int BW = DW / 8;

  dmem_state_t   state_r, state_s;
  logic [WS_W-1:0] cnt_r, cnt_s;
  dmem_op_t      op_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [BW-1:0] be_r;
  logic          ready_r, rvalid_r;

  logic          accept_s, access_s, in_range_s;
  dmem_op_t      req_op_s, acc_op_s;
  logic [AW-1:0] acc_addr_s;
  logic [DW-1:0] acc_wdata_s, rdata_s;
  logic [BW-1:0] req_be_s, acc_be_s;

`ifdef DMEM_BYTE_EN
  assign req_be_s = bus.d_be;
`else
  assign req_be_s = {BW{1'b1}};
`endif

  assign accept_s = ready_r && (bus.MemRead ^ bus.MemWrite);
  assign req_op_s = bus.MemWrite ? OP_WR : OP_RD;

  // With zero wait states the access happens on the acceptance edge, so use live inputs then.
  assign acc_op_s    = accept_s ? req_op_s    : op_r;
  assign acc_addr_s  = accept_s ? bus.daddr   : addr_r;
  assign acc_wdata_s = accept_s ? bus.ddata_w : wdata_r;
  assign acc_be_s    = accept_s ? req_be_s    : be_r;
  assign in_range_s  = 32'(acc_addr_s) < 32'(data_size);
  assign access_s    = (state_s == RESP);

  // next-state and wait counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          if (WAIT_STATES > 0) begin
            state_s = WAIT;
            cnt_s   = WS_W'(WAIT_STATES - 1);
          end else begin
            state_s = RESP;
            cnt_s   = {WS_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
          cnt_s   = {WS_W{1'b0}};
        end
      end
      WAIT: begin
        if (cnt_r == {WS_W{1'b0}}) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {WS_W{1'b0}};
      end
    endcase
  end

  // FSM state, counter and registered handshake outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= IDLE;
      cnt_r    <= {WS_W{1'b0}};
      ready_r  <= 1'b1;
      rvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ready_r  <= (state_s != WAIT);
      rvalid_r <= access_s;
    end
  end

  // request latch so the core may change its inputs after acceptance
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_r    <= OP_RD;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      be_r    <= {BW{1'b0}};
    end else if (accept_s) begin
      op_r    <= req_op_s;
      addr_r  <= bus.daddr;
      wdata_r <= bus.ddata_w;
      be_r    <= req_be_s;
    end
  end

  dmem_array #(
    .DEPTH (data_size),
    .DW    (DW),
    .AW    (AW)
  ) u_array (
    .clk   (CLK),
    .rst_n (RESET_N),
    .we    (access_s && (acc_op_s == OP_WR) && in_range_s),
    .re    (access_s && (acc_op_s == OP_RD)),
    .rzero (!in_range_s),
    .addr  (acc_addr_s),
    .wdata (acc_wdata_s),
    .be    (acc_be_s),
    .rdata (rdata_s)
  );

  assign bus.d_ready  = ready_r;
  assign bus.d_rvalid = rvalid_r;
  assign bus.ddata_r  = rdata_s;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a cycle-indexed transaction model. Honours DMEM_BYTE_EN.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int DW    = 32;
  localparam int WS    = 1;
  localparam int AW    = $clog2(DEPTH - 1);
  localparam int BW    = DW / 8;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b1;

  dmem_if #(.AW(AW), .DW(DW)) bus ();

  dmem_responder #(
    .data_size    (DEPTH),
    .address_size (DW),
    .WAIT_STATES  (WS)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Transaction model: a request presented in cycle n while ready is answered in cycle n+WS+1,
  // and the responder is busy until then. Memory effects apply in the response cycle.
  int            cyc      = 0;
  int            ready_at = 0;
  int            resp_cyc = 0;
  bit            pend     = 1'b0;
  bit            pend_wr;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [BW-1:0] pend_be;
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  logic [DW-1:0] last_rd  = '0;
  bit            rd_known = 1'b1;
  logic [AW-1:0] pool [8];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.daddr    = a;
    bus.ddata_w  = d;
`ifdef DMEM_BYTE_EN
    bus.d_be     = be;
`endif
  endtask

  // Called at a falling edge: check this cycle's outputs, then present this cycle's inputs.
  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic          exp_rv;
    logic [DW-1:0] w;
    exp_rv = pend && (resp_cyc == cyc);
    if (exp_rv) begin
      pend = 1'b0;
      if (pend_wr) begin
        w = mem_m.exists(pend_addr) ? mem_m[pend_addr] : {DW{1'bx}};
        for (int i = 0; i < BW; i++)
          if (pend_be[i]) w[8*i +: 8] = pend_data[8*i +: 8];
        mem_m[pend_addr] = w;
      end else begin
        rd_known = mem_m.exists(pend_addr);
        if (rd_known) last_rd = mem_m[pend_addr];
      end
    end
    chk("d_rvalid", bus.d_rvalid, exp_rv);
    chk("d_ready", bus.d_ready, cyc >= ready_at);
    if (rd_known) chk("ddata_r", bus.ddata_r, last_rd);
    drive(rd, wr, a, d, be);
    if ((cyc >= ready_at) && (rd ^ wr)) begin
      pend      = 1'b1;
      pend_wr   = wr;
      pend_addr = a;
      pend_data = d;
`ifdef DMEM_BYTE_EN
      pend_be   = be;
`else
      pend_be   = {BW{1'b1}};
`endif
      resp_cyc  = cyc + WS + 1;
      ready_at  = resp_cyc;
    end
    @(negedge CLK);
    cyc++;
  endtask

  // Present a request until the model says it was accepted (bounded).
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 16 && !acc; k++) begin
      acc = (cyc >= ready_at);
      step(rd, wr, a, d, be);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Asynchronous reset pulse starting at a falling edge, released before the next rising edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, '0);
    RESET_N = 1'b0;
    #1;
    chk("rst_ready", bus.d_ready, 1'b1);
    chk("rst_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_ddata_r", bus.ddata_r, 32'h0000_0000);
    pend     = 1'b0;
    ready_at = 0;
    last_rd  = '0;
    rd_known = 1'b1;
    #2;
    RESET_N = 1'b1;
    @(negedge CLK);
    cyc++;
  endtask

  initial begin
    logic [DW-1:0] rv;
    int            r;
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);

    // reset and quiet idle
    do_reset();
    idle(5);

    // write then read with wait states
    issue(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    chk("wait_ready", bus.d_ready, 1'b0);
    idle(1);
    chk("wr_rvalid", bus.d_rvalid, 1'b1);
    issue(1'b1, 1'b0, 10'h010, 32'h0, 4'hF);
    chk("wait_ready_rd", bus.d_ready, 1'b0);
    idle(3);
    chk("rd_deadbeef", bus.ddata_r, 32'hDEADBEEF);

    // back-to-back at the top address
    issue(1'b0, 1'b1, 10'h3FF, 32'h0000_0055, 4'hF);
    issue(1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF);
    idle(3);
    chk("b2b_raw", bus.ddata_r, 32'h0000_0055);

    // simultaneous read and write is ignored
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 10'h010, 32'hFFFF_FFFF, 4'hF);
    chk("illegal_rvalid", bus.d_rvalid, 1'b0);
    chk("illegal_ready", bus.d_ready, 1'b1);
    idle(2);

    // reset during a pending write, then rewrite
    issue(1'b0, 1'b1, 10'h020, 32'h1234_5678, 4'hF);
    chk("rst_wait_ready", bus.d_ready, 1'b0);
    do_reset();
    issue(1'b0, 1'b1, 10'h020, 32'hAAAA_AAAA, 4'hF);
    issue(1'b1, 1'b0, 10'h020, 32'h0, 4'hF);
    idle(3);
    chk("rst_rewrite", bus.ddata_r, 32'hAAAA_AAAA);

    // reset during a pending write leaves the old word intact
    issue(1'b0, 1'b1, 10'h020, 32'h1111_1111, 4'hF);
    idle(3);
    issue(1'b0, 1'b1, 10'h020, 32'h1234_5678, 4'hF);
    mem_m[10'h020] = 32'h1111_1111;
    do_reset();
    issue(1'b1, 1'b0, 10'h020, 32'h0, 4'hF);
    idle(3);
    chk("rst_drop_write", bus.ddata_r, 32'h1111_1111);

`ifdef DMEM_BYTE_EN
    issue(1'b0, 1'b1, 10'h005, 32'h0000_0000, 4'hF);
    issue(1'b0, 1'b1, 10'h005, 32'hFFFF_FFFF, 4'b0101);
    issue(1'b1, 1'b0, 10'h005, 32'h0, 4'hF);
    idle(3);
    chk("byte_en", bus.ddata_r, 32'h00FF_00FF);
    issue(1'b0, 1'b1, 10'h005, 32'h1234_5678, 4'b0000);
    issue(1'b1, 1'b0, 10'h005, 32'h0, 4'hF);
    idle(3);
    chk("byte_en_none", bus.ddata_r, 32'h00FF_00FF);
`endif

    // randomized traffic over a small address pool including both ends
    pool[0] = 10'h000;
    pool[1] = 10'h3FF;
    for (int i = 2; i < 8; i++) pool[i] = AW'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, pool[i], DW'($urandom), 4'hF);
    idle(3);
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      rv = DW'($urandom);
      if (r <= 3)      step(1'b1, 1'b0, pool[$urandom_range(0, 7)], rv, BW'($urandom));
      else if (r <= 6) step(1'b0, 1'b1, pool[$urandom_range(0, 7)], rv, BW'($urandom));
      else if (r == 7) step(1'b1, 1'b1, pool[$urandom_range(0, 7)], rv, BW'($urandom));
      else             idle(1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
